// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage.
//   word_t         32-bit machine word
//   fetch_state_t  fetch controller states
//   WBYTES         byte stride between consecutive instruction words
//   word_align()   clears the byte-offset bits of an address
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t WBYTES = 32'd4;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: instruction word, its pc+4 and a valid flag.
//   clk_i, rst_ni  clock and synchronous active-low reset
//   load_i         capture instr_i/npc_i and mark valid
//   flush_i        insert a bubble (valid=0, instr=NOP_INSTR); wins over load_i
//   instr_i/npc_i  data to capture
//   instr_o/npc_o/valid_o  latch contents
// With neither load_i nor flush_i the contents hold.
module if_id_latch
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] npc_i,
  output logic [31:0] instr_o,
  output logic [31:0] npc_o,
  output logic        valid_o
);

  word_t instr_q;
  word_t npc_q;
  logic  valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // npc is meaningless for a bubble, so it is left alone.
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      npc_q   <= npc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to the icache and
// feeds the IF/ID latch. A one-entry hold buffer absorbs a hit that lands
// while decode is stalled.
//   CLK, nRST               clock, synchronous active-low reset
//   ihit, iload             icache response (word for iaddr this cycle)
//   iREN, iaddr             icache request; iaddr is the word-aligned pc
//   stall                   hold IF/ID, do not advance
//   redirect, redirect_pc   taken control transfer resolved downstream
//   halt_in                 permanent stop until reset
//   if_instr, if_npc, if_valid  IF/ID contents
//   dbg_state               current controller state
// Handshake: the icache request is level-based. iREN stays high with iaddr
// stable until a cycle with ihit=1; that cycle consumes iload. ihit is only
// looked at while iREN is high.
// Per-cycle priority: halt_in > redirect > stall > ihit.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  logic [31:0]  iload,
  output logic         iREN,
  output logic [31:0]  iaddr,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         halt_in,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_npc,
  output logic         if_valid,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        hbuf_instr_q, hbuf_instr_d;
  word_t        hbuf_npc_q, hbuf_npc_d;
  word_t        pc_plus4;

  logic  lat_load;
  logic  lat_flush;
  word_t lat_instr;
  word_t lat_npc;

  // Modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0.
  assign pc_plus4 = pc_q + WBYTES;

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= word_align(PC_INIT);
      hbuf_instr_q <= '0;
      hbuf_npc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_npc_q   <= hbuf_npc_d;
    end
  end

  // Next-state logic. The hold buffer is full exactly when in HOLD, so
  // leaving HOLD is what empties it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_npc_d   = hbuf_npc_q;
    if (halt_in) begin
      state_d = HALTED;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect) begin
            pc_d = word_align(redirect_pc);
          end else if (ihit) begin
            pc_d = pc_plus4;
            if (stall) begin
              hbuf_instr_d = iload;
              hbuf_npc_d   = pc_plus4;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = word_align(redirect_pc);
            state_d = FETCH;
          end else if (!stall) begin
            state_d = FETCH;
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  // Outputs: icache request and IF/ID latch controls.
  always_comb begin
    iREN      = nRST && (state_q == FETCH);
    iaddr     = word_align(pc_q);
    lat_load  = 1'b0;
    lat_flush = 1'b0;
    lat_instr = iload;
    lat_npc   = pc_plus4;
    if (halt_in || (state_q == HALTED) || redirect) begin
      // A same-cycle hit is dropped along with the bubble.
      lat_flush = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!stall) begin
            if (ihit) lat_load  = 1'b1;
            else      lat_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            lat_load  = 1'b1;
            lat_instr = hbuf_instr_q;
            lat_npc   = hbuf_npc_q;
          end
        end
        default: lat_flush = 1'b1;
      endcase
    end
  end

  if_id_latch #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .load_i  (lat_load),
    .flush_i (lat_flush),
    .instr_i (lat_instr),
    .npc_i   (lat_npc),
    .instr_o (if_instr),
    .npc_o   (if_npc),
    .valid_o (if_valid)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// transaction-level reference model of the fetch stage.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  localparam logic [31:0] PC_INIT   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst;
  logic         ihit;
  logic [31:0]  iload;
  logic         iren;
  logic [31:0]  iaddr;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         halt_in;
  logic [31:0]  if_instr;
  logic [31:0]  if_npc;
  logic         if_valid;
  fetch_state_t dbg_state;

  fetch_stage #(
    .PC_INIT  (PC_INIT),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .CLK        (clk),
    .nRST       (nrst),
    .ihit       (ihit),
    .iload      (iload),
    .iREN       (iren),
    .iaddr      (iaddr),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_in    (halt_in),
    .if_instr   (if_instr),
    .if_npc     (if_npc),
    .if_valid   (if_valid),
    .dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the fetch stage as a PC, an optional parked word,
  // a halted flag and the IF/ID triple.
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_parked;
  logic [31:0] m_park_instr;
  logic [31:0] m_park_npc;
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_npc;

  function automatic logic model_req();
    return nrst && !m_halted && !m_parked;
  endfunction

  task automatic model_edge();
    if (!nrst) begin
      m_pc = PC_INIT; m_halted = 0; m_parked = 0;
      m_v = 0; m_instr = NOP_INSTR; m_npc = 0;
    end else if (m_halted || halt_in) begin
      m_halted = 1; m_parked = 0; m_v = 0; m_instr = NOP_INSTR;
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'd3; m_parked = 0; m_v = 0; m_instr = NOP_INSTR;
    end else if (m_parked) begin
      if (!stall) begin
        m_v = 1; m_instr = m_park_instr; m_npc = m_park_npc; m_parked = 0;
      end
    end else if (ihit) begin
      if (stall) begin
        m_parked = 1; m_park_instr = iload; m_park_npc = m_pc + 4;
      end else begin
        m_v = 1; m_instr = iload; m_npc = m_pc + 4;
      end
      m_pc = m_pc + 4;
    end else if (!stall) begin
      m_v = 0; m_instr = NOP_INSTR;
    end
  endtask

  // Driver: inputs are set by the caller; advance one clock and the model.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic h, input logic s, input logic r,
                       input logic [31:0] rpc, input logic hl);
    ihit = h; stall = s; redirect = r; redirect_pc = rpc; halt_in = hl;
    iload = $urandom;
  endtask

  task automatic test_reset();
    nrst = 0;
    drive(1, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (iren !== 1'b0) begin
      n_err++; $display("FAIL reset_iren got=%0b exp=0", iren);
    end
    step(); step();
    nrst = 1;
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (iren !== 1'b1 || iaddr !== PC_INIT || if_valid !== 1'b0 || if_instr !== NOP_INSTR ||
        if_npc !== 32'h0 || dbg_state !== FETCH) begin
      n_err++;
      $display("FAIL reset_state got iren=%0b iaddr=%h v=%0b instr=%h npc=%h exp 1 %h 0 %h 0",
               iren, iaddr, if_valid, if_instr, if_npc, PC_INIT, NOP_INSTR);
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      w = iload;
      n_vec++;
      if (iren !== 1'b1 || iaddr !== 32'(i * 4)) begin
        n_err++; $display("FAIL stream_addr%0d got=%h exp=%h", i, iaddr, i * 4);
      end
      step();
      n_vec++;
      if (if_valid !== 1'b1 || if_instr !== w || if_npc !== 32'(i * 4 + 4)) begin
        n_err++;
        $display("FAIL stream_ifid%0d got v=%0b instr=%h npc=%h exp 1 %h %h",
                 i, if_valid, if_instr, if_npc, w, i * 4 + 4);
      end
    end
  endtask

  task automatic test_miss();
    logic [31:0] w;
    drive(0, 0, 1, 32'h10, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      n_vec++;
      if (iren !== 1'b1 || iaddr !== 32'h10) begin
        n_err++; $display("FAIL miss_req%0d got iren=%0b iaddr=%h exp 1 10", i, iren, iaddr);
      end
      step();
      n_vec++;
      if (if_valid !== 1'b0 || if_instr !== NOP_INSTR) begin
        n_err++; $display("FAIL miss_bubble%0d got v=%0b instr=%h exp 0", i, if_valid, if_instr);
      end
    end
    drive(1, 0, 0, 0, 0);
    w = iload;
    step();
    n_vec++;
    if (if_valid !== 1'b1 || if_instr !== w || if_npc !== 32'h14 || iaddr !== 32'h14) begin
      n_err++;
      $display("FAIL miss_done got v=%0b instr=%h npc=%h iaddr=%h exp 1 %h 14 14",
               if_valid, if_instr, if_npc, iaddr, w);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] w1c, w20;
    drive(0, 0, 1, 32'h1C, 0);
    step();
    drive(1, 0, 0, 0, 0);
    w1c = iload;
    step();
    drive(1, 1, 0, 0, 0);
    w20 = iload;
    step();
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), 1, 0, 0, 0);
      n_vec++;
      if (iren !== 1'b0 || dbg_state !== HOLD || if_valid !== 1'b1 || if_instr !== w1c ||
          if_npc !== 32'h20) begin
        n_err++;
        $display("FAIL hold_%0d got iren=%0b v=%0b instr=%h npc=%h exp 0 1 %h 20",
                 i, iren, if_valid, if_instr, if_npc, w1c);
      end
      step();
    end
    n_vec++;
    if (if_instr !== w1c) begin
      n_err++; $display("FAIL hold_end got instr=%h exp=%h", if_instr, w1c);
    end
    drive(0, 0, 0, 0, 0);
    step();
    n_vec++;
    if (if_valid !== 1'b1 || if_instr !== w20 || if_npc !== 32'h24 || iaddr !== 32'h24 ||
        iren !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release got v=%0b instr=%h npc=%h iaddr=%h iren=%0b exp 1 %h 24 24 1",
               if_valid, if_instr, if_npc, iaddr, iren, w20);
    end
  endtask

  task automatic test_redirect();
    // FETCH with hit, stall and redirect together.
    drive(1, 1, 1, 32'h103, 0);
    step();
    n_vec++;
    if (if_valid !== 1'b0 || iaddr !== 32'h100 || iren !== 1'b1) begin
      n_err++;
      $display("FAIL redir_fetch got v=%0b iaddr=%h iren=%0b exp 0 100 1", if_valid, iaddr, iren);
    end
    drive(0, 0, 0, 0, 0);
    step();
    n_vec++;
    if (if_valid !== 1'b0 || iaddr !== 32'h100) begin
      n_err++; $display("FAIL redir_noload got v=%0b iaddr=%h exp 0 100", if_valid, iaddr);
    end
    // Redirect while a word is parked: the parked word must vanish.
    drive(1, 1, 0, 0, 0);
    step();
    drive(0, 1, 1, 32'h202, 0);
    step();
    drive(0, 0, 0, 0, 0);
    n_vec++;
    if (iren !== 1'b1 || iaddr !== 32'h200 || if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_hold got iren=%0b iaddr=%h v=%0b exp 1 200 0", iren, iaddr, if_valid);
    end
    step();
    n_vec++;
    if (if_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_discard got v=%0b exp 0", if_valid);
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] w;
    drive(0, 0, 1, 32'hFFFF_FFFF, 0);
    step();
    n_vec++;
    if (iaddr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_addr got=%h exp=fffffffc", iaddr);
    end
    drive(1, 0, 0, 0, 0);
    w = iload;
    step();
    n_vec++;
    if (if_valid !== 1'b1 || if_instr !== w || if_npc !== 32'h0 || iaddr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_npc got v=%0b instr=%h npc=%h iaddr=%h exp 1 %h 0 0",
               if_valid, if_instr, if_npc, iaddr, w);
    end
    drive(1, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    // Reset mid-miss at pc=4, with a late hit arriving during reset.
    nrst = 0;
    drive(1, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (iren !== 1'b0) begin
      n_err++; $display("FAIL midmiss_iren got=%0b exp=0", iren);
    end
    step();
    nrst = 1;
    drive(0, 0, 0, 0, 0);
    #1;
    n_vec++;
    if (iaddr !== PC_INIT || iren !== 1'b1 || if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midmiss_refetch got iaddr=%h iren=%0b v=%0b exp %h 1 0",
               iaddr, iren, if_valid, PC_INIT);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom, 0);
      n_vec++;
      if (iren !== model_req() || iaddr !== m_pc) begin
        n_err++;
        $display("FAIL rand_req%0d got iren=%0b iaddr=%h exp %0b %h",
                 i, iren, iaddr, model_req(), m_pc);
      end
      step();
      n_vec++;
      if (if_valid !== m_v || if_instr !== m_instr || (m_v && if_npc !== m_npc)) begin
        n_err++;
        $display("FAIL rand_ifid%0d got v=%0b instr=%h npc=%h exp %0b %h %h",
                 i, if_valid, if_instr, if_npc, m_v, m_instr, m_npc);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    drive(0, 0, 1, 32'h0000_0400, 0);
    step();
    frozen = 32'h400;
    drive(1, $urandom_range(0, 1), 0, 0, 1);
    step();
    for (int i = 0; i < 6; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0);
      n_vec++;
      if (iren !== 1'b0 || if_valid !== 1'b0 || if_instr !== NOP_INSTR || iaddr !== frozen ||
          dbg_state !== HALTED) begin
        n_err++;
        $display("FAIL halt_%0d got iren=%0b v=%0b instr=%h iaddr=%h exp 0 0 %h %h",
                 i, iren, if_valid, if_instr, iaddr, NOP_INSTR, frozen);
      end
      step();
    end
    nrst = 0;
    drive(0, 0, 0, 0, 0);
    step();
    nrst = 1;
    #1;
    n_vec++;
    if (iren !== 1'b1 || iaddr !== PC_INIT) begin
      n_err++; $display("FAIL halt_reset got iren=%0b iaddr=%h exp 1 %h", iren, iaddr, PC_INIT);
    end
  endtask

  initial begin
    nrst = 0; ihit = 0; iload = 0; stall = 0; redirect = 0; redirect_pc = 0; halt_in = 0;
    m_pc = PC_INIT; m_halted = 0; m_parked = 0; m_park_instr = 0; m_park_npc = 0;
    m_v = 0; m_instr = NOP_INSTR; m_npc = 0;
    test_reset();
    test_stream();
    test_miss();
    test_stall_hold();
    test_redirect();
    test_wrap_reset();
    test_random();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
